alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Execution/writeback stage directly upstream of the 4-entry register_file. It consumes that block's read ports and drives its write port.
- Accepts one instruction at a time over a valid/ready handshake and drives read selects.
- Computes the result: single-cycle ALU ops, or a 32-iteration shift-add multiply.
- Writes the result back with a one-cycle load_enable pulse.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a power of 2.
- ADDR_WIDTH, 2, register select width.
- SHAMT_WIDTH, 5, shift-amount bits taken from operand B; equals log2(DATA_WIDTH).

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept
- instr_op  in  3  opcode
- instr_a  in  ADDR_WIDTH  source A register
- instr_b  in  ADDR_WIDTH  source B register
- instr_dest  in  ADDR_WIDTH  destination register
- A_select  out  ADDR_WIDTH  to register file read port A
- B_select  out  ADDR_WIDTH  to register file read port B
- A_data  in  DATA_WIDTH  combinational read data A
- B_data  in  DATA_WIDTH  combinational read data B
- dest_select  out  ADDR_WIDTH  write address
- D_data  out  DATA_WIDTH  write data
- load_enable  out  1  write strobe, one cycle
- done  out  1  one-cycle pulse, coincident with load_enable
- result_zero  out  1  registered; result of last completed op == 0
- busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset effect: state=IDLE; all outputs 0, including instr_ready (held low while reset=1), load_enable, done, result_zero, D_data and selects.
- Reset priority: reset overrides everything. Reset mid-EXEC/MUL/WB aborts the op with no register write.
- Opcodes, all arithmetic modulo 2^DATA_WIDTH, operands unsigned:
  - 000 ADD A+B
  - 001 SUB A-B (wraps, e.g. 0-1=0xFFFFFFFF)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL A<<B[SHAMT_WIDTH-1:0]; upper bits of B ignored
  - 110 MUL, low DATA_WIDTH bits of A*B
  - 111 MOV, result=A
- instr_ready = (state==IDLE) & ~reset. Handshake fires on valid&ready at a rising edge; op and dest are latched there.
- A_select, B_select and dest_select are registered at acceptance and held until the next acceptance.
- State IDLE: waits for handshake, then EXEC.
- State EXEC (one cycle):
  - A_data/B_data are valid this cycle.
  - Non-MUL ops: result registered, then WB.
  - MUL: operands captured (multiplicand, multiplier, acc=0, count=0), then MUL.
- State MUL: one iteration per cycle.
  - If multiplier[0], acc+=multiplicand.
  - multiplicand<<=1; multiplier>>=1.
  - After DATA_WIDTH iterations (count==DATA_WIDTH-1), goes to WB.
  - No early termination.
- State WB (one cycle):
  - load_enable=1, done=1, D_data=result, dest_select=dest.
  - result_zero updated at this edge.
  - Next state IDLE.
- Outside WB: load_enable=0 and done=0. D_data holds the last result.
- Latency, handshake at edge ending cycle t:
  - Single-cycle ops: EXEC in t+1, WB in t+2, register file updated at the end of t+2, instr_ready high in t+3.
  - MUL: EXEC in t+1, MUL in t+2..t+33, WB in t+34.
- No hazards: the next instruction reads in its EXEC, after the previous write edge, so back-to-back dependent ops see updated data. No forwarding is needed.
- Same-register cases: dest may equal A or B (e.g. r1=r1+r1), and A may equal B. Both are legal.
- instr_valid while busy is ignored; fields are not sampled.
- Throughput: one instruction per 3 cycles, or per DATA_WIDTH+3 for MUL.

Test Plan:
- Bench setup: connect to the 4-entry register_file and preload r0=5, r1=7, r2=0xFFFFFFFF, r3=0 via bench-driven writes before handing over.
- ADD r3=r0+r1 -> load_enable pulse exactly 2 cycles after handshake; r3=12; done coincident; result_zero=0; instr_ready low for 2 cycles.
- SUB r3=r3-r3 then ADD r0=r2+r1:
  - SUB gives r3=0, result_zero=1.
  - ADD gives r0=6 (wrap), result_zero=0.
  - Back-to-back dependent ops read updated values.
- SHL r1=r1<<r0 with r0=0x25 -> shift of 5 (upper B bits ignored); r1=224.
- MUL r2=r2*r1 with r1=7 -> WB exactly 34 cycles after handshake; r2=0xFFFFFFF9; busy high throughout; instr_valid held high during busy not accepted.
- Reset asserted mid-MUL (cycle t+10) -> no load_enable, r2 unchanged, all outputs 0 on next edge, instr_ready stays 0 while reset=1 and rises the cycle after reset deasserts.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: execute/writeback stage that sits in front of a small register file.
//
// It accepts one instruction at a time over a valid/ready handshake and drives the
// register-file read selects. The result comes either from a single-cycle ALU op or
// from a 32-iteration shift-add multiply. It is then written back with a one-cycle
// load_enable strobe.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   instr_valid/ready   instruction handshake (ready only in IDLE and not in reset)
//   instr_op/a/b/dest   opcode, source registers, destination register
//   A_select, B_select  registered read selects to the register file
//   A_data, B_data      combinational read data, consumed in EXEC
//   dest_select, D_data write address and write data
//   load_enable, done   one-cycle pulse in WB
//   result_zero         registered zero flag of the last completed op
//   busy                high whenever not IDLE
module alu_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 2,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_a,
  input  logic [ADDR_WIDTH-1:0] instr_b,
  input  logic [ADDR_WIDTH-1:0] instr_dest,
  output logic [ADDR_WIDTH-1:0] A_select,
  output logic [ADDR_WIDTH-1:0] B_select,
  input  logic [DATA_WIDTH-1:0] A_data,
  input  logic [DATA_WIDTH-1:0] B_data,
  output logic [ADDR_WIDTH-1:0] dest_select,
  output logic [DATA_WIDTH-1:0] D_data,
  output logic                  load_enable,
  output logic                  done,
  output logic                  result_zero,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StExec, StMul, StWb} state_e;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpMul = 3'b110;
  localparam logic [2:0] OpMov = 3'b111;

  localparam logic [SHAMT_WIDTH-1:0] LastIter = SHAMT_WIDTH'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] a_sel_q, a_sel_d;
  logic [ADDR_WIDTH-1:0] b_sel_q, b_sel_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [SHAMT_WIDTH-1:0] count_q, count_d;
  logic                  result_zero_q, result_zero_d;

  logic                  accept;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] acc_next;

  // Ready is gated by reset directly so it reads low for the whole reset window.
  assign instr_ready = (state_q == StIdle) & ~reset;
  assign accept      = instr_valid & instr_ready;

  always_comb begin
    alu_res = '0;
    unique case (op_q)
      OpAdd: alu_res = A_data + B_data;
      OpSub: alu_res = A_data - B_data;
      OpAnd: alu_res = A_data & B_data;
      OpOr:  alu_res = A_data | B_data;
      OpXor: alu_res = A_data ^ B_data;
      OpShl: alu_res = A_data << B_data[SHAMT_WIDTH-1:0];
      OpMul: alu_res = '0; // multiply runs in StMul
      OpMov: alu_res = A_data;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add the multiplicand when the current multiplier LSB is set.
  always_comb begin
    acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_sel_d       = a_sel_q;
    b_sel_d       = b_sel_q;
    dest_d        = dest_q;
    result_d      = result_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    acc_d         = acc_q;
    count_d       = count_q;
    result_zero_d = result_zero_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = instr_op;
          a_sel_d = instr_a;
          b_sel_d = instr_b;
          dest_d  = instr_dest;
          state_d = StExec;
        end
      end
      StExec: begin
        if (op_q == OpMul) begin
          mcand_d  = A_data;
          mplier_d = B_data;
          acc_d    = '0;
          count_d  = '0;
          state_d  = StMul;
        end else begin
          result_d = alu_res;
          state_d  = StWb;
        end
      end
      StMul: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + SHAMT_WIDTH'(1);
        if (count_q == LastIter) begin
          result_d = acc_next;
          state_d  = StWb;
        end
      end
      StWb: begin
        result_zero_d = (result_q == '0);
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      op_q          <= '0;
      a_sel_q       <= '0;
      b_sel_q       <= '0;
      dest_q        <= '0;
      result_q      <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      acc_q         <= '0;
      count_q       <= '0;
      result_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_sel_q       <= a_sel_d;
      b_sel_q       <= b_sel_d;
      dest_q        <= dest_d;
      result_q      <= result_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      acc_q         <= acc_d;
      count_q       <= count_d;
      result_zero_q <= result_zero_d;
    end
  end

  assign A_select    = a_sel_q;
  assign B_select    = b_sel_q;
  assign dest_select = dest_q;
  assign D_data      = result_q;
  assign load_enable = (state_q == StWb);
  assign done        = (state_q == StWb);
  assign result_zero = result_zero_q;
  assign busy        = (state_q != StIdle);

endmodule
